// File: rtl/mod3_rr_arbiter.sv
// Three-way round-robin arbiter with a mod-3 priority pointer, explicit release,
// owner-drop release and an optional hold-cycle timeout.
module mod3_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned HW       = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [2:0] req,
  input  logic       rel,
  output logic [2:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  localparam bit              HOLD_EN   = (HOLD_MAX != 0);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_EN ? HOLD_MAX - 1 : 0);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nxt;
  logic [1:0]    ptr, ptr_nxt;
  logic [HW-1:0] hold, hold_nxt;
  logic [2:0]    gnt_nxt;
  logic [1:0]    gnt_id_nxt;
  logic          busy_nxt;
  logic          timeout_nxt;

  logic [1:0]    ptr_eff;
  logic [1:0]    win;
  logic          own_req;
  logic          hold_lim;

  // First requester at or after the pointer, wrapping mod 3; ptr=3 behaves as 0.
  always_comb begin
    ptr_eff = (ptr == 2'd3) ? 2'd0 : ptr;
    win     = 2'd0;
    case (ptr_eff)
      2'd1:    win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd2:    win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  assign own_req  = |(req & gnt);
  assign hold_lim = HOLD_EN && (hold == HOLD_LAST);

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    hold_nxt    = hold;
    gnt_nxt     = gnt;
    gnt_id_nxt  = gnt_id;
    busy_nxt    = busy;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        gnt_nxt    = 3'b000;
        gnt_id_nxt = 2'd0;
        busy_nxt   = 1'b0;
        hold_nxt   = '0;
        if (|req) begin
          state_nxt  = GRANT;
          gnt_nxt    = 3'b001 << win;
          gnt_id_nxt = win;
          busy_nxt   = 1'b1;
          ptr_nxt    = (win == 2'd2) ? 2'd0 : win + 2'd1;
        end
      end
      GRANT: begin
        hold_nxt = hold + HW'(1);
        if (rel || !own_req || hold_lim) begin
          state_nxt   = IDLE;
          gnt_nxt     = 3'b000;
          gnt_id_nxt  = 2'd0;
          busy_nxt    = 1'b0;
          hold_nxt    = '0;
          // Flag only releases forced purely by the hold limit.
          timeout_nxt = hold_lim && !rel && own_req;
        end
      end
      default: begin
        state_nxt  = IDLE;
        gnt_nxt    = 3'b000;
        gnt_id_nxt = 2'd0;
        busy_nxt   = 1'b0;
        hold_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      hold    <= '0;
      gnt     <= 3'b000;
      gnt_id  <= 2'd0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      hold    <= hold_nxt;
      gnt     <= gnt_nxt;
      gnt_id  <= gnt_id_nxt;
      busy    <= busy_nxt;
      timeout <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_mod3_rr_arbiter.sv
// Directed self-checking bench for mod3_rr_arbiter (HOLD_MAX=8).
module tb_mod3_rr_arbiter;

  logic       clk = 1'b0;
  logic       clr;
  logic [2:0] req;
  logic       rel;
  logic [2:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  mod3_rr_arbiter #(.HOLD_MAX(8), .HW(4)) dut (
    .clk     (clk),
    .clr     (clr),
    .req     (req),
    .rel     (rel),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compares the full output set; gnt_id and busy follow from the expected gnt.
  task automatic chk(input string tag, input logic [2:0] e_gnt, input logic e_to);
    logic [1:0] e_id;
    e_id = e_gnt[2] ? 2'd2 : (e_gnt[1] ? 2'd1 : 2'd0);
    check({tag, ".gnt"},     32'(gnt),     32'(e_gnt));
    check({tag, ".gnt_id"},  32'(gnt_id),  32'(e_id));
    check({tag, ".busy"},    32'(busy),    32'(|e_gnt));
    check({tag, ".timeout"}, 32'(timeout), 32'(e_to));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1; req = 3'b000; rel = 1'b0;
    tick();
    clr = 1'b0;
  endtask

  logic [2:0] order [4];

  initial begin
    clr = 1'b1; req = 3'b111; rel = 1'b0;

    // 1: reset holds everything at zero even with all requests up
    tick(); chk("rst1", 3'b000, 1'b0);
    tick(); chk("rst2", 3'b000, 1'b0);
    clr = 1'b0;

    // 2: rel on 2nd cycle of each grant -> 0,1,2,0 with dead cycles
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
    for (int i = 0; i < 4; i++) begin
      tick(); chk($sformatf("rr%0d.c1", i), order[i], 1'b0);
      tick(); chk($sformatf("rr%0d.c2", i), order[i], 1'b0);
      rel = 1'b1;
      tick(); chk($sformatf("rr%0d.dead", i), 3'b000, 1'b0);
      rel = 1'b0;
    end
    req = 3'b000;
    tick(); chk("rr.idle", 3'b000, 1'b0);

    // 3: lone request from 1 moves pointer to 2, so 2 beats 0 next
    do_reset();
    req = 3'b010;
    tick(); chk("p.g1", 3'b010, 1'b0);
    rel = 1'b1;
    tick(); chk("p.rel", 3'b000, 1'b0);
    rel = 1'b0; req = 3'b101;
    tick(); chk("p.g2", 3'b100, 1'b0);
    req = 3'b001;                         // owner drops
    tick(); chk("p.drop", 3'b000, 1'b0);
    tick(); chk("p.g0", 3'b001, 1'b0);
    req = 3'b011;                         // non-owner change ignored
    tick(); chk("p.hold", 3'b001, 1'b0);
    req = 3'b000;
    tick(); chk("p.end", 3'b000, 1'b0);

    // 4: hold limit -> exactly 8 grant cycles then one timeout cycle
    do_reset();
    req = 3'b001;
    tick(); chk("to.c1", 3'b001, 1'b0);
    for (int i = 2; i <= 8; i++) begin
      tick(); chk($sformatf("to.c%0d", i), 3'b001, 1'b0);
    end
    tick(); chk("to.pulse", 3'b000, 1'b1);
    tick(); chk("to.regrant", 3'b001, 1'b0);

    // 5: rel on the 8th cycle coincides with limit -> plain release
    for (int i = 2; i <= 7; i++) begin
      tick(); chk($sformatf("rl.c%0d", i), 3'b001, 1'b0);
    end
    tick(); chk("rl.c8", 3'b001, 1'b0);
    rel = 1'b1;
    tick(); chk("rl.rel", 3'b000, 1'b0);
    rel = 1'b0;
    tick(); chk("rl.g", 3'b001, 1'b0);
    tick(); chk("rl.c2b", 3'b001, 1'b0);
    tick(); chk("rl.c3b", 3'b001, 1'b0);
    req = 3'b000;
    tick(); chk("rl.drop", 3'b000, 1'b0);
    // rel together with owner drop -> single release
    req = 3'b001;
    tick(); chk("rd.g", 3'b001, 1'b0);
    req = 3'b000; rel = 1'b1;
    tick(); chk("rd.rel", 3'b000, 1'b0);
    rel = 1'b0;
    tick(); chk("rd.idle", 3'b000, 1'b0);

    // 6: clr mid-grant to 1 drops gnt and resets pointer
    do_reset();
    req = 3'b111;
    tick(); chk("cl.g0", 3'b001, 1'b0);
    rel = 1'b1;
    tick(); chk("cl.r0", 3'b000, 1'b0);
    rel = 1'b0;
    tick(); chk("cl.g1", 3'b010, 1'b0);
    clr = 1'b1;
    tick(); chk("cl.clr", 3'b000, 1'b0);
    clr = 1'b0;
    tick(); chk("cl.after", 3'b001, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
